// File: rtl/mtl_pkg.sv
// Shared timing defaults and controller state encoding for the MTL panel controller.
// Combinational definitions only; no latency or backpressure.
package mtl_pkg;

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FRONT_DEF   = 210;
  localparam int H_SYNC_DEF    = 30;
  localparam int H_BACK_DEF    = 16;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 22;
  localparam int V_SYNC_DEF    = 13;
  localparam int V_BACK_DEF    = 10;

  localparam int PIPE_DLY_DEF     = 2;
  localparam int START_FRAMES_DEF = 4;

  function automatic int span_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = span_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = span_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  typedef enum logic {BLANK, RUN} state_t;

endpackage

// File: rtl/sync_delay_line.sv
// Reset-initialised shift register; latency DEPTH clocks (DEPTH=0 is a plain wire).
// No backpressure: shifts every clock.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK_33,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge CLK_33 or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mtl_display_controller.sv
// MTL panel timing generator with start-up blanking; pins lag x_cnt/y_cnt by PIPE_DLY+1 clocks.
// No backpressure: free-running pixel clock, renderer must track the coordinates.
module mtl_display_controller
  import mtl_pkg::*;
#(
  parameter int H_VISIBLE    = H_VISIBLE_DEF,
  parameter int H_FRONT      = H_FRONT_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BACK       = H_BACK_DEF,
  parameter int V_VISIBLE    = V_VISIBLE_DEF,
  parameter int V_FRONT      = V_FRONT_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BACK       = V_BACK_DEF,
  parameter int PIPE_DLY     = PIPE_DLY_DEF,
  parameter int START_FRAMES = START_FRAMES_DEF
) (
  input  logic        CLK_33,
  input  logic        reset,
  input  logic [23:0] Qbert_RGB,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  output logic        MTL_HSD,
  output logic        MTL_VSD,
  output logic [7:0]  MTL_R,
  output logic [7:0]  MTL_G,
  output logic [7:0]  MTL_B,
  output logic        MTL_DE,
  output logic        new_frame,
  output logic [15:0] frame_cnt,
  output logic        running
);

  localparam int H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] X_VIS  = 11'(H_VISIBLE);
  localparam logic [9:0]  Y_VIS  = 10'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  state_t state, state_nxt;
  logic   x_wrap, frame_end;
  logic   raw_de, raw_hs, raw_vs;
  logic   de_d, hs_d, vs_d;

  assign x_wrap    = (x_cnt == X_LAST);
  assign frame_end = x_wrap && (y_cnt == Y_LAST);

  always_ff @(posedge CLK_33 or posedge reset) begin
    if (reset) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      frame_cnt <= '0;
      state     <= BLANK;
    end else begin
      if (x_wrap) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 10'd1;
      end else begin
        x_cnt <= x_cnt + 11'd1;
      end
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      state <= state_nxt;
    end
  end

  // frame_cnt still equals the number of completed frames while in BLANK
  always_comb begin
    state_nxt = state;
    case (state)
      BLANK: if (START_FRAMES == 0 || (frame_end && (int'(frame_cnt) + 1 == START_FRAMES)))
               state_nxt = RUN;
      RUN:   state_nxt = RUN;
      default: state_nxt = BLANK;
    endcase
  end

  assign running   = (state == RUN);
  assign new_frame = (x_cnt == '0) && (y_cnt == '0) && !reset;

  assign raw_de = (x_cnt < X_VIS) && (y_cnt < Y_VIS) && (state == RUN);
  assign raw_hs = !((x_cnt >= HS_BEG) && (x_cnt < HS_END));
  assign raw_vs = !((y_cnt >= VS_BEG) && (y_cnt < VS_END));

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (3'b011)
  ) u_sync_dly (
    .CLK_33 (CLK_33),
    .reset  (reset),
    .din    ({raw_de, raw_hs, raw_vs}),
    .dout   ({de_d, hs_d, vs_d})
  );

  always_ff @(posedge CLK_33 or posedge reset) begin
    if (reset) begin
      MTL_DE  <= 1'b0;
      MTL_HSD <= 1'b1;
      MTL_VSD <= 1'b1;
      {MTL_R, MTL_G, MTL_B} <= '0;
    end else begin
      MTL_DE  <= de_d;
      MTL_HSD <= hs_d;
      MTL_VSD <= vs_d;
      {MTL_R, MTL_G, MTL_B} <= de_d ? Qbert_RGB : 24'h0;
    end
  end

endmodule

// File: tb/tb_mtl_display_controller.sv
// Directed bench on a shrunken raster: 15 clocks x 8 lines = 120 clocks per frame.
// Visible x<8,y<4; hsync low x=11..12; vsync low y=6.
module tb_mtl_display_controller;

  logic        CLK_33 = 1'b0;
  logic        reset  = 1'b1;
  logic [23:0] Qbert_RGB = '0;

  logic [10:0] x_cnt, x_cnt_0;
  logic [9:0]  y_cnt, y_cnt_0;
  logic        MTL_HSD, MTL_VSD, MTL_DE, new_frame, running;
  logic        MTL_HSD_0, MTL_VSD_0, MTL_DE_0, new_frame_0, running_0;
  logic [7:0]  MTL_R, MTL_G, MTL_B, MTL_R_0, MTL_G_0, MTL_B_0;
  logic [15:0] frame_cnt, frame_cnt_0;

  always #5 CLK_33 = ~CLK_33;

  mtl_display_controller #(
    .H_VISIBLE(8), .H_FRONT(3), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(1), .V_BACK(1),
    .PIPE_DLY(2), .START_FRAMES(2)
  ) dut (
    .CLK_33(CLK_33), .reset(reset), .Qbert_RGB(Qbert_RGB),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .MTL_HSD(MTL_HSD), .MTL_VSD(MTL_VSD),
    .MTL_R(MTL_R), .MTL_G(MTL_G), .MTL_B(MTL_B), .MTL_DE(MTL_DE),
    .new_frame(new_frame), .frame_cnt(frame_cnt), .running(running)
  );

  mtl_display_controller #(
    .H_VISIBLE(8), .H_FRONT(3), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(1), .V_BACK(1),
    .PIPE_DLY(1), .START_FRAMES(0)
  ) dut0 (
    .CLK_33(CLK_33), .reset(reset), .Qbert_RGB(Qbert_RGB),
    .x_cnt(x_cnt_0), .y_cnt(y_cnt_0), .MTL_HSD(MTL_HSD_0), .MTL_VSD(MTL_VSD_0),
    .MTL_R(MTL_R_0), .MTL_G(MTL_G_0), .MTL_B(MTL_B_0), .MTL_DE(MTL_DE_0),
    .new_frame(new_frame_0), .frame_cnt(frame_cnt_0), .running(running_0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic vis(input int p);
    return (p >= 0) && ((p % 15) < 8) && (((p / 15) % 8) < 4);
  endfunction

  function automatic logic [23:0] enc(input int p);
    return {8'(p % 15), 8'((p / 15) % 8), 8'(p / 120)};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},   32'(x_cnt), 0);
    chk({tag, "_y"},   32'(y_cnt), 0);
    chk({tag, "_fc"},  32'(frame_cnt), 0);
    chk({tag, "_run"}, 32'(running), 0);
    chk({tag, "_de"},  32'(MTL_DE), 0);
    chk({tag, "_rgb"}, 32'({MTL_R, MTL_G, MTL_B}), 0);
    chk({tag, "_hsd"}, 32'(MTL_HSD), 1);
    chk({tag, "_vsd"}, 32'(MTL_VSD), 1);
    chk({tag, "_nf"},  32'(new_frame), 0);
    chk({tag, "_run0"}, 32'(running_0), 0);
  endtask

  initial begin
    logic [23:0] drv, prev;
    logic        e_de, e_de0, e_hs, e_vs;
    int          p, p0;
    int          de_f01, de_f2, de0_f0, hs_low, vs_low;
    de_f01 = 0; de_f2 = 0; de0_f0 = 0; hs_low = 0; vs_low = 0;

    repeat (3) @(negedge CLK_33);
    chk_reset_vals("rst");

    // k counts rising edges since release; bench sample k sees raw position k-3
    reset = 1'b0;
    drv = 24'hD85F02; Qbert_RGB = drv; prev = drv;
    #1;
    chk("nf_release", 32'(new_frame), 1);
    chk("x_release",  32'(x_cnt), 0);

    for (int k = 1; k <= 600; k++) begin
      @(negedge CLK_33);
      p  = k - 3;
      p0 = k - 2;
      e_de  = (p >= 240) && vis(p);
      e_de0 = (p0 >= 1) && vis(p0);
      e_hs  = (p < 0) || !(((p % 15) == 11) || ((p % 15) == 12));
      e_vs  = (p < 0) || (((p / 15) % 8) != 6);

      chk("x",   32'(x_cnt), 32'(k % 15));
      chk("y",   32'(y_cnt), 32'((k / 15) % 8));
      chk("fc",  32'(frame_cnt), 32'(k / 120));
      chk("nf",  32'(new_frame), 32'(k % 120 == 0));
      chk("run", 32'(running), 32'(k >= 240));
      chk("de",  32'(MTL_DE), 32'(e_de));
      chk("hsd", 32'(MTL_HSD), 32'(e_hs));
      chk("vsd", 32'(MTL_VSD), 32'(e_vs));
      chk("rgb", 32'({MTL_R, MTL_G, MTL_B}), 32'(e_de ? prev : 24'h0));
      chk("de0", 32'(MTL_DE_0), 32'(e_de0));
      chk("rgb0", 32'({MTL_R_0, MTL_G_0, MTL_B_0}), 32'(e_de0 ? prev : 24'h0));
      chk("run0", 32'(running_0), 1);

      if (k == 242) chk("de_before_run", 32'(MTL_DE), 0);
      if (k == 243) chk("de_rise", 32'(MTL_DE), 1);
      if (k == 243) chk("rgb_const", 32'({MTL_R, MTL_G, MTL_B}), 32'h00D85F02);
      if (k == 398) chk("rgb_pix_x5_y2", 32'({MTL_R, MTL_G, MTL_B}), 32'h00050203);

      if (k >= 3 && k <= 362) begin
        if (!MTL_HSD) hs_low++;
        if (!MTL_VSD) vs_low++;
      end
      if (k >= 3 && k <= 242 && MTL_DE) de_f01++;
      if (k >= 243 && k <= 362 && MTL_DE) de_f2++;
      if (k >= 2 && k <= 121 && MTL_DE_0) de0_f0++;

      drv = (k < 360) ? 24'hD85F02 : enc(k - 2);
      Qbert_RGB = drv;
      prev = drv;
    end

    chk("hs_low_3fr", 32'(hs_low), 48);
    chk("vs_low_3fr", 32'(vs_low), 45);
    chk("de_blank_fr", 32'(de_f01), 0);
    chk("de_run_fr", 32'(de_f2), 32);
    chk("de0_fr0", 32'(de0_f0), 31);

    // move to x=5, y=2 of frame 5, then reset mid-frame between edges
    repeat (35) @(negedge CLK_33);
    chk("pre_rst_x", 32'(x_cnt), 5);
    chk("pre_rst_y", 32'(y_cnt), 2);
    #2 reset = 1'b1;
    #1 chk_reset_vals("arst");
    repeat (5) @(posedge CLK_33);
    @(negedge CLK_33);
    chk_reset_vals("arst_hold");
    reset = 1'b0;
    #1 chk("nf_rerelease", 32'(new_frame), 1);

    for (int k = 1; k <= 241; k++) begin
      @(negedge CLK_33);
      if (k == 1) begin
        chk("rr_x", 32'(x_cnt), 1);
        chk("rr_y", 32'(y_cnt), 0);
        chk("rr_fc", 32'(frame_cnt), 0);
        chk("rr_run0", 32'(running_0), 1);
      end
      if (k == 239) chk("rr_run_blank", 32'(running), 0);
      if (k == 240) chk("rr_run_on", 32'(running), 1);
      if (k == 240) chk("rr_fc2", 32'(frame_cnt), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mtl_display_controller.md
MTL_DISPLAY_CONTROLLER -- requirements
Module: mtl_display_controller

Interface
REQ-001 Parameter H_VISIBLE, 800: visible pixels per line.
REQ-002 Parameter H_FRONT, 210 / H_SYNC, 30 / H_BACK, 16: horizontal porch and sync widths in clocks; line total is 1056.
REQ-003 Parameter V_VISIBLE, 480 / V_FRONT, 22 / V_SYNC, 13 / V_BACK, 10: vertical widths in lines; frame total is 525.
REQ-004 Parameter PIPE_DLY, 2: clocks from x_cnt/y_cnt to a valid Qbert_RGB, range 0..7.
REQ-005 Parameter START_FRAMES, 4: blank frames forced after reset.
REQ-006 CLK_33  in  1  pixel clock; single clock domain.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 Qbert_RGB  in  24  pixel colour {R,G,B} from the map renderer, valid PIPE_DLY clocks after its coordinates.
REQ-009 x_cnt  out  11  current horizontal position, 0..1055.
REQ-010 y_cnt  out  10  current vertical position, 0..524.
REQ-011 MTL_HSD  out  1  horizontal sync, active-low.
REQ-012 MTL_VSD  out  1  vertical sync, active-low.
REQ-013 MTL_R, MTL_G, MTL_B  out  8 each  panel colour.
REQ-014 MTL_DE  out  1  data enable, high on visible pixels.
REQ-015 new_frame  out  1  single-clock pulse at the first visible pixel of each frame (as counted).
REQ-016 frame_cnt  out  16  frames completed since reset; wraps from 65535 to 0.
REQ-017 running  out  1  high once the start-up blanking has finished.

Function
REQ-018 x_cnt shall increment every clock and wrap from 1055 to 0; y_cnt shall increment on each x_cnt wrap and wrap from 524 to 0.
REQ-019 Both wraps at x=1055, y=524 shall occur in the same clock, giving x=0, y=0 next.
REQ-020 Visible region: x_cnt<800 and y_cnt<480.
REQ-021 Raw hsync is low for 1010<=x_cnt<=1039; raw vsync is low for 502<=y_cnt<=514.
REQ-022 Raw DE, raw hsync and raw vsync shall be delayed through a PIPE_DLY-stage shift register, then registered once more at the outputs, so MTL_DE, MTL_HSD and MTL_VSD align with MTL_R/G/B.
REQ-023 Qbert_RGB shall be registered once into MTL_R/G/B.
REQ-024 Total latency from x_cnt/y_cnt to MTL pins shall be PIPE_DLY+1 clocks.
REQ-025 MTL_R/G/B shall be 0 whenever the delayed DE is low.
REQ-026 The controller has two states, BLANK and RUN.
REQ-027 BLANK: MTL_DE=0 and RGB=0; syncs run normally; leave for RUN after START_FRAMES completed frames.
REQ-028 RUN: pixels pass through; there is no return to BLANK except via reset.
REQ-029 A frame completes on the clock where x=1055 and y=524; frame_cnt increments on that clock, +1 modulo 2^16.
REQ-030 new_frame is asserted, undelayed, while x_cnt=0 and y_cnt=0, in both states.
REQ-031 running=1 exactly in RUN.
REQ-032 START_FRAMES=0 shall enter RUN on the first clock after reset release.

Reset
REQ-033 On reset assertion, immediately and regardless of clock: x_cnt=0, y_cnt=0, state=BLANK, frame_cnt=0, running=0, MTL_DE=0, RGB=0, MTL_HSD=1, MTL_VSD=1, new_frame=0, all delay stages cleared to the inactive level.
REQ-034 Reset mid-frame shall restart at x=0, y=0 on the first clock after release, with a full START_FRAMES blanking.

Structure
REQ-035 Timing constants, derived totals and the BLANK/RUN state enum shall reside in shared package mtl_pkg.
REQ-036 The delay line shall be one sub-module, sync_delay_line, parameterised by width and depth, with depth 0 meaning a wire.
REQ-037 The target size is 120-400 RTL lines.

Verification
REQ-038 Release reset, run 3 frames -> MTL_HSD low for exactly 30 clocks per 1056 period; MTL_VSD low for 13 lines per 525 lines.
REQ-039 PIPE_DLY=2, Qbert_RGB=24'hD85F02 constant -> MTL_DE rises 3 clocks after x_cnt=0, y_cnt=0; RGB=0 during frames 0..3; 216/95/2 from frame 4 with DE; running rises at the end of frame 3.
REQ-040 Drive Qbert_RGB = x_cnt delayed by 2 -> each MTL_R/G/B sample shows a pixel index matching its DE position; 800 DE clocks per line; 480 DE lines per frame.
REQ-041 Assert reset at x=400, y=200 for 5 clocks -> all outputs are at reset values during assertion; x=0, y=0 one clock after release; frame_cnt=0.
REQ-042 Force frame_cnt near 65535 (or run long) -> wraps to 0; new_frame still pulses once per frame, 554400 clocks apart.
REQ-043 START_FRAMES=0 -> running=1 on the first clock after reset release; DE active in frame 0.
